run_event_logger: RTL and testbench
===================================

Name: run_event_logger

Overview:
- Downstream consumer of the runDetect block.
- Watches the per-sample gt flag and the sample value, and measures each run of consecutive above-threshold samples.
- Runs of length >= MIN_RUN are recorded as {start index, length, peak value} in a small FIFO, which a host/readout stage drains over a valid/ready handshake.
- Arming shares strtCapCmp with runDetect, so index 0 lines up with the threshold-capture cycle.

Parameters:
DATA_W, 12, width of sig sample
IDX_W, 16, width of sample index counter
LEN_W, 8, width of run-length field
DEPTH, 4, record FIFO depth (power of 2, >= 2)
MIN_RUN, 4, minimum run length that produces a record

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
strtCapCmp  in  1  arm/restart pulse; same signal that drives runDetect capture
smpl_vld  in  1  sig/gt qualify a new sample this cycle
sig  in  DATA_W  current sample value
gt  in  1  current sig > captured threshold (from runDetect datapath)
rec_vld  out  1  FIFO head record available
rec_rdy  in  1  consumer accepts head record
rec_start  out  IDX_W  index of the first sample of the run
rec_len  out  LEN_W  run length, saturating
rec_peak  out  DATA_W  maximum sig value within the run
ovfl  out  1  sticky: a qualifying record was dropped because the FIFO was full
in_run  out  1  FSM is currently inside a run

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, idx=0, FIFO empty, rec_vld=0, ovfl=0, in_run=0. rec_start/rec_len/rec_peak read 0 while empty.
- States:
  - IDLE: after reset; all samples ignored.
  - SEEK: armed, waiting for a run.
  - IN_RUN: inside a run.
- strtCapCmp (highest priority, any state):
  - next state SEEK; idx<=0; FIFO flushed; ovfl<=0; any run in progress is discarded.
  - The sample presented in the same cycle is ignored: it is the threshold-capture sample.
- Sample index:
  - In SEEK/IN_RUN, idx increments on every smpl_vld. The first sample after arming is index 0.
  - idx wraps modulo 2^IDX_W.
- SEEK transitions:
  - smpl_vld & gt -> IN_RUN; run_start<=idx, run_len<=1, run_peak<=sig.
- IN_RUN transitions:
  - smpl_vld & gt: run_len<=run_len+1, saturating at 2^LEN_W-1; run_peak<=max(run_peak, sig), unsigned compare.
  - smpl_vld & !gt: if run_len >= MIN_RUN, push {run_start, run_len, run_peak}; go to SEEK. The terminating sample does not start a run.
  - smpl_vld low: hold all state; gaps do not break a run.
- in_run = (state==IN_RUN), registered via state.
- FIFO:
  - First-word-fall-through; rec_vld = !empty; head fields driven directly.
  - Pop on rec_vld & rec_rdy.
  - Push latency: record visible (rec_vld=1) the cycle after the edge where the terminating sample is sampled.
- Boundary conditions:
  - Push when full and no pop: record dropped; ovfl<=1, held until strtCapCmp or reset.
  - Push and pop in the same cycle while full: both succeed, no ovfl.
  - Push and pop in the same cycle while empty: not possible; pop requires rec_vld.
  - Run in progress when strtCapCmp arrives: discarded, no record.
  - rec_rdy held high with an empty FIFO: no effect.
  - Pointers wrap modulo DEPTH; count width is log2(DEPTH)+1 to distinguish full from empty.

Decomposition:
- Package run_log_pkg holds:
  - state_t enum {IDLE, SEEK, IN_RUN}, 2-bit encoding.
  - run_rec_t packed struct {start, len, peak}.
  - Parameter defaults.
- One sub-module: run_rec_fifo (sync FIFO of run_rec_t, DEPTH entries, push/pop/full/empty, flush input).
- The FSM, idx counter, and run accumulators live in run_event_logger.

Test Plan:
- Reset, then strtCapCmp; 10 samples with gt pattern 0,1,1,1,1,1,0,0,0,0 (sig=5,9,30,7,12,3,...) -> one record start=1, len=5, peak=30; rec_vld rises the cycle after sample 6.
- Run of 3 (gt at idx 2..4) then gt=0 -> no record, rec_vld stays 0, in_run falls after idx 5.
- rec_rdy=0; generate 5 qualifying runs with DEPTH=4 -> 4 records held, ovfl=1; drain -> the records are the first 4 in order; then strtCapCmp -> ovfl=0.
- FIFO full while a run terminates with rec_rdy=1 in the same cycle -> no ovfl, head advances, new record lands at the tail.
- 300 consecutive gt samples with smpl_vld gaps -> len saturates at 255, peak correct, gaps do not split the run; strtCapCmp mid-run -> no record, idx restarts at 0.
- rst_n low for one cycle mid-run with records queued -> all outputs 0 next cycle, state IDLE; samples are ignored until strtCapCmp.

Source files
------------

// File: rtl/run_event_logger_pkg.sv
// Shared types and defaults for the run event logger slice.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: state_t (FSM encoding), run_rec_t (one logged run), width
// localparams that fix the record layout, and a saturating increment helper.
package run_log_pkg;

   // Record layout widths; the record struct is built from these.
   localparam int DATA_W      = 12;
   localparam int IDX_W       = 16;
   localparam int LEN_W       = 8;

   // Defaults for the per-instance knobs of the logger.
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_MIN_RUN = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEEK   = 2'd1,
      IN_RUN = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  start;
      logic [LEN_W-1:0]  len;
      logic [DATA_W-1:0] peak;
   } run_rec_t;

   // Run length sticks at all-ones instead of wrapping.
   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      return (v == '1) ? v : v + LEN_W'(1);
   endfunction

endpackage

// File: rtl/run_event_logger_if.sv
// Sample-in / record-out bundle between the logger and its host.
// Latency: n/a (wires only).
// Backpressure: rec_vld/rec_rdy handshake on the record side; samples have none.
//
// master: the logger (consumes samples, produces records).
// slave : the host/readout stage.
interface run_event_logger_if;
   import run_log_pkg::*;

   logic              strtCapCmp;
   logic              smpl_vld;
   logic [DATA_W-1:0] sig;
   logic              gt;
   logic              rec_vld;
   logic              rec_rdy;
   logic [IDX_W-1:0]  rec_start;
   logic [LEN_W-1:0]  rec_len;
   logic [DATA_W-1:0] rec_peak;
   logic              ovfl;
   logic              in_run;

   modport master (
      input  strtCapCmp, smpl_vld, sig, gt, rec_rdy,
      output rec_vld, rec_start, rec_len, rec_peak, ovfl, in_run
   );

   modport slave (
      output strtCapCmp, smpl_vld, sig, gt, rec_rdy,
      input  rec_vld, rec_start, rec_len, rec_peak, ovfl, in_run
   );
endinterface

// File: rtl/run_event_logger_fifo.sv
// Synchronous first-word-fall-through FIFO of run records with flush.
// Latency: a push is visible at the head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports: clk, rst_n (sync, active low), flush, push/wr_dat, pop,
//        rd_dat (zero while empty), full, empty.
module run_rec_fifo
   import run_log_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     flush,
   input  logic     push,
   input  run_rec_t wr_dat,
   input  logic     pop,
   output run_rec_t rd_dat,
   output logic     full,
   output logic     empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   run_rec_t        mem_q [DEPTH];
   run_rec_t        mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

   // When full, a same-cycle pop frees the slot the push is about to use.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/run_event_logger.sv
// Measures runs of consecutive above-threshold samples and queues long ones.
// Latency: record at the FIFO head the cycle after the terminating sample's edge.
// Backpressure: rec_vld/rec_rdy; records arriving at a full FIFO are dropped, ovfl set.
//
// Ports: clk, rst_n (sync, active low), bus (master modport): strtCapCmp,
//        smpl_vld, sig, gt, rec_rdy in; rec_vld, rec_start, rec_len, rec_peak,
//        ovfl, in_run out.
module run_event_logger
   import run_log_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int MIN_RUN = DEF_MIN_RUN
) (
   input  logic                clk,
   input  logic                rst_n,
   run_event_logger_if.master  bus
);
   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [IDX_W-1:0]  run_start_q, run_start_d;
   logic [LEN_W-1:0]  run_len_q, run_len_d;
   logic [DATA_W-1:0] run_peak_q, run_peak_d;
   logic              ovfl_q, ovfl_d;
   logic              in_run_q, in_run_d;

   logic              push, pop, flush, full, empty;
   run_rec_t          wr_rec, head;

   assign pop    = ~empty & bus.rec_rdy;
   assign wr_rec = '{start: run_start_q, len: run_len_q, peak: run_peak_q};

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      run_start_d = run_start_q;
      run_len_d   = run_len_q;
      run_peak_d  = run_peak_q;
      ovfl_d      = ovfl_q;
      push        = 1'b0;
      flush       = 1'b0;

      if (bus.strtCapCmp) begin
         // The sample in this cycle is the threshold-capture sample: ignored.
         state_d = SEEK;
         idx_d   = '0;
         ovfl_d  = 1'b0;
         flush   = 1'b1;
      end else if (bus.smpl_vld) begin
         case (state_q)
            SEEK: begin
               idx_d = idx_q + IDX_W'(1);
               if (bus.gt) begin
                  state_d     = IN_RUN;
                  run_start_d = idx_q;
                  run_len_d   = LEN_W'(1);
                  run_peak_d  = bus.sig;
               end
            end
            IN_RUN: begin
               idx_d = idx_q + IDX_W'(1);
               if (bus.gt) begin
                  run_len_d = sat_inc(run_len_q);
                  if (bus.sig > run_peak_q) run_peak_d = bus.sig;
               end else begin
                  push    = (run_len_q >= LEN_W'(MIN_RUN));
                  state_d = SEEK;
               end
            end
            default: ;
         endcase
      end

      if (push && full && !pop) ovfl_d = 1'b1;

      in_run_d = (state_d == IN_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         run_start_q <= '0;
         run_len_q   <= '0;
         run_peak_q  <= '0;
         ovfl_q      <= 1'b0;
         in_run_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         run_start_q <= run_start_d;
         run_len_q   <= run_len_d;
         run_peak_q  <= run_peak_d;
         ovfl_q      <= ovfl_d;
         in_run_q    <= in_run_d;
      end
   end

   run_rec_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .push   (push),
      .wr_dat (wr_rec),
      .pop    (pop),
      .rd_dat (head),
      .full   (full),
      .empty  (empty)
   );

   assign bus.rec_vld   = ~empty;
   assign bus.rec_start = head.start;
   assign bus.rec_len   = head.len;
   assign bus.rec_peak  = head.peak;
   assign bus.ovfl      = ovfl_q;
   assign bus.in_run    = in_run_q;

endmodule

// File: tb/tb_run_event_logger.sv
// Directed bench for run_event_logger: a per-cycle vector table plus
// hand-written sequences for overflow, full push+pop, saturation, re-arm
// and reset.
module tb_run_event_logger;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   run_event_logger_if bus();

   run_event_logger #(.DEPTH(4), .MIN_RUN(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        strt, sv;
      logic [11:0] sig;
      logic        gt, rdy;
      logic        e_vld;
      logic [15:0] e_start;
      logic [7:0]  e_len;
      logic [11:0] e_peak;
      logic        e_ovfl, e_inrun;
   } vec_t;

   vec_t tbl [22];

   function automatic vec_t mk(logic s, logic v, int d, logic g, logic r,
                               logic ev, int es, int el, int ep,
                               logic eo, logic ei);
      vec_t t;
      t.strt = s; t.sv = v; t.sig = 12'(d); t.gt = g; t.rdy = r;
      t.e_vld = ev; t.e_start = 16'(es); t.e_len = 8'(el); t.e_peak = 12'(ep);
      t.e_ovfl = eo; t.e_inrun = ei;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ev, input int es, input int el,
                          input int ep, input logic eo, input logic ei);
      chk({tag, ".rec_vld"},   32'(bus.rec_vld),   32'(ev));
      chk({tag, ".rec_start"}, 32'(bus.rec_start), 32'(es));
      chk({tag, ".rec_len"},   32'(bus.rec_len),   32'(el));
      chk({tag, ".rec_peak"},  32'(bus.rec_peak),  32'(ep));
      chk({tag, ".ovfl"},      32'(bus.ovfl),      32'(eo));
      chk({tag, ".in_run"},    32'(bus.in_run),    32'(ei));
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
   task automatic step(input logic s, input logic v, input int d, input logic g, input logic r);
      bus.strtCapCmp = s;
      bus.smpl_vld   = v;
      bus.sig        = 12'(d);
      bus.gt         = g;
      bus.rec_rdy    = r;
      @(posedge clk);
      #1;
   endtask

   // Run k: four gt samples (peak 103+10k, not last), then one terminating sample.
   task automatic do_run(input int k, input logic term_rdy);
      step(0, 1, 100 + 10*k, 1, 0);
      step(0, 1, 103 + 10*k, 1, 0);
      step(0, 1, 101 + 10*k, 1, 0);
      step(0, 1, 102 + 10*k, 1, 0);
      step(0, 1, 0, 0, term_rdy);
   endtask

   initial begin
      // strt, smpl_vld, sig, gt, rdy | vld, start, len, peak, ovfl, in_run
      tbl[0]  = mk(1,1,100,1,0, 0, 0,0,  0,0,0); // arm; capture sample ignored
      tbl[1]  = mk(0,1,  5,0,0, 0, 0,0,  0,0,0); // idx0
      tbl[2]  = mk(0,1,  9,1,0, 0, 0,0,  0,0,1); // idx1 run starts
      tbl[3]  = mk(0,1, 30,1,0, 0, 0,0,  0,0,1);
      tbl[4]  = mk(0,1,  7,1,0, 0, 0,0,  0,0,1);
      tbl[5]  = mk(0,0,4000,1,0,0, 0,0,  0,0,1); // gap: not a sample
      tbl[6]  = mk(0,1, 12,1,0, 0, 0,0,  0,0,1);
      tbl[7]  = mk(0,1,  3,1,0, 0, 0,0,  0,0,1); // idx5
      tbl[8]  = mk(0,1,  1,0,0, 1, 1,5, 30,0,0); // idx6 terminates
      tbl[9]  = mk(0,1,  1,0,0, 1, 1,5, 30,0,0);
      tbl[10] = mk(0,0,  0,0,1, 0, 0,0,  0,0,0); // pop
      tbl[11] = mk(0,0,  0,0,1, 0, 0,0,  0,0,0); // rdy on empty
      tbl[12] = mk(0,1, 50,1,0, 0, 0,0,  0,0,1); // idx8
      tbl[13] = mk(0,1, 60,1,0, 0, 0,0,  0,0,1);
      tbl[14] = mk(0,1, 70,1,0, 0, 0,0,  0,0,1);
      tbl[15] = mk(0,1,  0,0,0, 0, 0,0,  0,0,0); // run of 3: dropped
      tbl[16] = mk(0,1, 10,1,0, 0, 0,0,  0,0,1); // idx12
      tbl[17] = mk(0,1,200,1,0, 0, 0,0,  0,0,1);
      tbl[18] = mk(0,1, 20,1,0, 0, 0,0,  0,0,1);
      tbl[19] = mk(0,1,199,1,0, 0, 0,0,  0,0,1);
      tbl[20] = mk(0,1,  0,0,0, 1,12,4,200,0,0); // exactly MIN_RUN
      tbl[21] = mk(1,0,  0,0,0, 0, 0,0,  0,0,0); // re-arm flushes

      // Reset state
      step(0, 1, 77, 1, 0);
      step(0, 1, 77, 1, 0);
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      step(0, 1, 77, 1, 0);
      chk_all("idle_ignores", 0, 0, 0, 0, 0, 0);

      // Vector table
      for (int i = 0; i < 22; i++) begin
         step(tbl[i].strt, tbl[i].sv, int'(tbl[i].sig), tbl[i].gt, tbl[i].rdy);
         chk_all($sformatf("vec%0d", i), tbl[i].e_vld, int'(tbl[i].e_start),
                 int'(tbl[i].e_len), int'(tbl[i].e_peak), tbl[i].e_ovfl, tbl[i].e_inrun);
      end

      // Overflow: five runs, no reads
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) do_run(k, 0);
      chk_all("ovf.after5", 1, 0, 4, 103, 1, 0);
      for (int k = 0; k < 4; k++) begin
         chk_all($sformatf("ovf.drain%0d", k), 1, 5*k, 4, 103 + 10*k, 1, 0);
         step(0, 0, 0, 0, 1);
      end
      chk("ovf.empty", 32'(bus.rec_vld), 0);
      chk("ovf.sticky", 32'(bus.ovfl), 1);
      step(1, 0, 0, 0, 0);
      chk("ovf.clear", 32'(bus.ovfl), 0);

      // Full FIFO with push and pop in the same cycle
      for (int k = 0; k < 4; k++) do_run(k, 0);
      chk_all("fpp.full", 1, 0, 4, 103, 0, 0);
      do_run(4, 1);
      chk_all("fpp.pushpop", 1, 5, 4, 113, 0, 0);
      for (int k = 1; k < 5; k++) begin
         chk_all($sformatf("fpp.drain%0d", k), 1, 5*k, 4, 103 + 10*k, 0, 0);
         step(0, 0, 0, 0, 1);
      end
      chk("fpp.empty", 32'(bus.rec_vld), 0);

      // 300-sample run with gaps: saturation and peak
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         if (i % 7 == 3) begin
            step(0, 0, 4095, 0, 0);
            chk($sformatf("sat.gap%0d.in_run", i), 32'(bus.in_run), 1);
         end
         step(0, 1, (i == 137) ? 3000 : (i % 256), 1, 0);
         chk($sformatf("sat.s%0d.in_run", i), 32'(bus.in_run), 1);
      end
      step(0, 1, 0, 0, 0);
      chk_all("sat.rec", 1, 0, 255, 3000, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(0, 1, 40, 1, 0);
      chk("sat.run2.in_run", 32'(bus.in_run), 1);
      step(1, 1, 40, 1, 0);
      chk_all("sat.abort", 0, 0, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 8 + i, 1, 0);
      step(0, 1, 0, 0, 0);
      chk_all("sat.rearm_idx", 1, 1, 4, 11, 0, 0);
      step(0, 0, 0, 0, 1);

      // Reset mid-run with a record queued
      step(1, 0, 0, 0, 0);
      step(0, 1, 7, 1, 0);
      step(0, 1, 8, 1, 0);
      step(0, 1, 9, 1, 0);
      step(0, 1, 6, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 50, 1, 0);
      step(0, 1, 60, 1, 0);
      chk_all("rst.before", 1, 0, 4, 9, 0, 1);
      rst_n = 1'b0;
      step(0, 1, 70, 1, 0);
      chk_all("rst.cleared", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(0, 1, 90, 1, 0);
      chk("rst.idle.in_run", 32'(bus.in_run), 0);
      step(0, 1, 0, 0, 0);
      chk("rst.idle.rec_vld", 32'(bus.rec_vld), 0);
      step(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) step(0, 1, i, 1, 0);
      step(0, 1, 0, 0, 0);
      chk_all("rst.rearm", 1, 0, 4, 4, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
